// File: rtl/sap1_pkg.sv
// SAP-1 controller constants: opcodes, sequencer states and the 12-bit control word layout.
package sap1_pkg;

  localparam int NUM_T = 6;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_HALT = 2'd2
  } seq_state_t;

  // Bit positions within con; _N bits are active-low.
  localparam int CON_CP   = 11;
  localparam int CON_EP   = 10;
  localparam int CON_LM_N = 9;
  localparam int CON_CE_N = 8;
  localparam int CON_LI_N = 7;
  localparam int CON_EI_N = 6;
  localparam int CON_LA_N = 5;
  localparam int CON_EA   = 4;
  localparam int CON_SU   = 3;
  localparam int CON_EU   = 2;
  localparam int CON_LB_N = 1;
  localparam int CON_LO_N = 0;

  function automatic logic [11:0] bit_at(int idx);
    return 12'b1 << idx;
  endfunction

  localparam logic [11:0] CON_IDLE = 12'h3E3;

  localparam logic [11:0] CON_T1     = (CON_IDLE | bit_at(CON_EP)) & ~bit_at(CON_LM_N);
  localparam logic [11:0] CON_T2     = CON_IDLE | bit_at(CON_CP);
  localparam logic [11:0] CON_T3     = CON_IDLE & ~(bit_at(CON_CE_N) | bit_at(CON_LI_N));
  localparam logic [11:0] CON_T4_MAR = CON_IDLE & ~(bit_at(CON_LM_N) | bit_at(CON_EI_N));
  localparam logic [11:0] CON_T5_LDA = CON_IDLE & ~(bit_at(CON_CE_N) | bit_at(CON_LA_N));
  localparam logic [11:0] CON_T5_LDB = CON_IDLE & ~(bit_at(CON_CE_N) | bit_at(CON_LB_N));
  localparam logic [11:0] CON_T6_ADD = (CON_IDLE | bit_at(CON_EU)) & ~bit_at(CON_LA_N);
  localparam logic [11:0] CON_T6_SUB = CON_T6_ADD | bit_at(CON_SU);
  localparam logic [11:0] CON_T4_OUT = (CON_IDLE | bit_at(CON_EA)) & ~bit_at(CON_LO_N);

endpackage

// File: rtl/ring_counter.sv
// One-hot T1..T6 ring with hold, sync load-T1 / sync clear, and async active-low clear.
module ring_counter
  import sap1_pkg::*;
(
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic             load,
  input  logic             adv,
  input  logic             clr,
  output logic [NUM_T-1:0] t
);

  logic [NUM_T-1:0] t_q;

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n)    t_q <= '0;
    else if (clr)  t_q <= '0;
    else if (load) t_q <= {{(NUM_T-1){1'b0}}, 1'b1};
    else if (adv)  t_q <= {t_q[NUM_T-2:0], t_q[NUM_T-1]};
  end

  assign t = t_q;

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 controller-sequencer: IDLE/RUN/HALT control around the T-state ring,
// plus the combinational instruction decoder producing the control word.
module control_sequencer
  import sap1_pkg::*;
(
  input  logic        CLK,
  input  logic        CLR_n,
  input  logic [3:0]  opcode,
  input  logic        run,
  output logic [11:0] con,
  output logic [5:0]  t_state,
  output logic        halted
);

  seq_state_t state_q, state_d;
  logic       rc_load, rc_adv, rc_clr;

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) state_q <= SEQ_IDLE;
    else        state_q <= state_d;
  end

  // run low freezes everything: no state change and the ring holds.
  always_comb begin
    state_d = state_q;
    rc_load = 1'b0;
    rc_adv  = 1'b0;
    rc_clr  = 1'b0;
    if (run) begin
      case (state_q)
        SEQ_IDLE: begin
          state_d = SEQ_RUN;
          rc_load = 1'b1;
        end
        SEQ_RUN: begin
          if (t_state[3] && opcode == OP_HLT) begin
            state_d = SEQ_HALT;
            rc_clr  = 1'b1;
          end else begin
            rc_adv  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  ring_counter u_ring (
    .CLK   (CLK),
    .CLR_n (CLR_n),
    .load  (rc_load),
    .adv   (rc_adv),
    .clr   (rc_clr),
    .t     (t_state)
  );

  assign halted = (state_q == SEQ_HALT);

  always_comb begin
    con = CON_IDLE;
    if (run && state_q == SEQ_RUN) begin
      case (t_state)
        6'b000001: con = CON_T1;
        6'b000010: con = CON_T2;
        6'b000100: con = CON_T3;
        6'b001000: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: con = CON_T4_MAR;
            OP_OUT:                 con = CON_T4_OUT;
            default:                con = CON_IDLE;
          endcase
        end
        6'b010000: begin
          case (opcode)
            OP_LDA:         con = CON_T5_LDA;
            OP_ADD, OP_SUB: con = CON_T5_LDB;
            default:        con = CON_IDLE;
          endcase
        end
        6'b100000: begin
          case (opcode)
            OP_ADD:  con = CON_T6_ADD;
            OP_SUB:  con = CON_T6_SUB;
            default: con = CON_IDLE;
          endcase
        end
        default: con = CON_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected {con, t_state, halted} pushed when driven, popped after sampling.
module tb_control_sequencer;

  typedef struct packed {
    logic [11:0] con;
    logic [5:0]  t;
    logic        h;
  } exp_t;

  logic        tb_clk;
  logic        CLR_n;
  logic [3:0]  opcode;
  logic        run;
  logic [11:0] con;
  logic [5:0]  t_state;
  logic        halted;

  int   checks;
  int   failures;
  exp_t sb_q[$];

  control_sequencer dut (
    .CLK     (tb_clk),
    .CLR_n   (CLR_n),
    .opcode  (opcode),
    .run     (run),
    .con     (con),
    .t_state (t_state),
    .halted  (halted)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_con"},    {20'd0, con},    {20'd0, e.con});
    chk({tag, "_tstate"}, {26'd0, t_state}, {26'd0, e.t});
    chk({tag, "_halted"}, {31'd0, halted}, {31'd0, e.h});
  endtask

  // Drive inputs for the coming edge, then compare the state it produces.
  task automatic step(input string tag, input logic r, input logic [3:0] op,
                      input logic [11:0] ec, input logic [5:0] et, input logic eh);
    run    = r;
    opcode = op;
    sb_q.push_back('{con: ec, t: et, h: eh});
    @(posedge tb_clk);
    #1;
    pop_cmp(tag);
  endtask

  // Compare combinational response without a clock edge.
  task automatic settle(input string tag, input logic [11:0] ec, input logic [5:0] et, input logic eh);
    sb_q.push_back('{con: ec, t: et, h: eh});
    #1;
    pop_cmp(tag);
  endtask

  task automatic fetch(input string tag, input logic [3:0] op);
    step({tag, "_t1"}, 1'b1, op, 12'h5E3, 6'b000001, 1'b0);
    step({tag, "_t2"}, 1'b1, op, 12'hBE3, 6'b000010, 1'b0);
    step({tag, "_t3"}, 1'b1, op, 12'h263, 6'b000100, 1'b0);
  endtask

  task automatic execute(input string tag, input logic [3:0] op,
                         input logic [11:0] c4, input logic [11:0] c5, input logic [11:0] c6);
    step({tag, "_t4"}, 1'b1, op, c4, 6'b001000, 1'b0);
    step({tag, "_t5"}, 1'b1, op, c5, 6'b010000, 1'b0);
    step({tag, "_t6"}, 1'b1, op, c6, 6'b100000, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    CLR_n    = 1'b0;
    run      = 1'b1;
    opcode   = 4'h0;

    #3;
    settle("reset", 12'h3E3, 6'b0, 1'b0);
    @(posedge tb_clk); #1;
    settle("reset_held", 12'h3E3, 6'b0, 1'b0);
    CLR_n = 1'b1;

    fetch("lda", 4'h0);
    execute("lda", 4'h0, 12'h1A3, 12'h2C3, 12'h3E3);
    fetch("add", 4'h1);
    execute("add", 4'h1, 12'h1A3, 12'h2E1, 12'h3C7);
    fetch("sub", 4'h2);
    execute("sub", 4'h2, 12'h1A3, 12'h2E1, 12'h3CF);
    fetch("nop", 4'h5);
    execute("nop", 4'h5, 12'h3E3, 12'h3E3, 12'h3E3);

    // Run gating in T2
    step("gate_t1", 1'b1, 4'h5, 12'h5E3, 6'b000001, 1'b0);
    step("gate_t2", 1'b1, 4'h5, 12'hBE3, 6'b000010, 1'b0);
    run = 1'b0;
    settle("gate_drop", 12'h3E3, 6'b000010, 1'b0);
    for (int i = 0; i < 5; i++)
      step("gate_hold", 1'b0, 4'h5, 12'h3E3, 6'b000010, 1'b0);
    run = 1'b1;
    settle("gate_resume", 12'hBE3, 6'b000010, 1'b0);
    step("gate_t3", 1'b1, 4'h5, 12'h263, 6'b000100, 1'b0);
    execute("out", 4'hE, 12'h3F2, 12'h3E3, 12'h3E3);

    // HLT then absorbing HALT
    fetch("hlt", 4'hF);
    step("hlt_t4", 1'b1, 4'hF, 12'h3E3, 6'b001000, 1'b0);
    step("hlt_enter", 1'b1, 4'hF, 12'h3E3, 6'b000000, 1'b1);
    for (int i = 0; i < 20; i++)
      step("halt_hold", 1'b1, 4'h0, 12'h3E3, 6'b000000, 1'b1);
    CLR_n = 1'b0;
    settle("halt_clr", 12'h3E3, 6'b000000, 1'b0);
    CLR_n = 1'b1;
    step("post_halt_t1", 1'b1, 4'h0, 12'h5E3, 6'b000001, 1'b0);
    step("post_halt_t2", 1'b1, 4'h0, 12'hBE3, 6'b000010, 1'b0);
    step("post_halt_t3", 1'b1, 4'h0, 12'h263, 6'b000100, 1'b0);
    step("post_halt_t4", 1'b1, 4'h0, 12'h1A3, 6'b001000, 1'b0);
    step("post_halt_t5", 1'b1, 4'h0, 12'h2C3, 6'b010000, 1'b0);

    // Async clear between edges in T5
    #2;
    CLR_n = 1'b0;
    settle("async_clr", 12'h3E3, 6'b000000, 1'b0);
    @(posedge tb_clk); #1;
    settle("async_clr_held", 12'h3E3, 6'b000000, 1'b0);
    CLR_n = 1'b1;
    step("restart_t1", 1'b1, 4'h1, 12'h5E3, 6'b000001, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
